// File: rtl/oitf_disp_ctrl.sv
// Dispatch/retire controller in front of the OITF: holds dispatch on hazards or a full OITF,
// allocates entries for long-pipe ops and arbitrates the retire port. DISP_RR_ARB_EN selects round-robin retire arbitration.
module oitf_disp_ctrl #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 3,
   parameter int REG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             disp_valid,
   output logic             disp_ready,
   input  logic             disp_long,
   input  logic             disp_rs1en,
   input  logic             disp_rs2en,
   input  logic [REG_W-1:0] disp_rs1idx,
   input  logic [REG_W-1:0] disp_rs2idx,
   input  logic [REG_W-1:0] disp_rdidx,
   input  logic             flush,
   output logic             drained,
   output logic             oitf_wreg,
   output logic [REG_W-1:0] oitf_wreg_rdidx,
   output logic             oitf_wb,
   output logic [REG_W-1:0] oitf_wb_rdidx,
   output logic             oitf_readen1,
   output logic             oitf_readen2,
   output logic [REG_W-1:0] oitf_readidx1,
   output logic [REG_W-1:0] oitf_readidx2,
   input  logic             oitf_match1,
   input  logic             oitf_match2,
   input  logic             mdu_wb_valid,
   input  logic [REG_W-1:0] mdu_wb_rdidx,
   output logic             mdu_wb_ready,
   input  logic             lsu_wb_valid,
   input  logic [REG_W-1:0] lsu_wb_rdidx,
   output logic             lsu_wb_ready,
   output logic [CNT_W-1:0] cnt,
   output logic             err_underflow
);

   // state | meaning
   // IDLE  | one cycle after reset, dispatch held
   // RUN   | normal dispatch
   // DRAIN | flush pending, dispatch held until no entries outstanding
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             mdu_win, lsu_win;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      disp_ready      = 1'b0;
      oitf_wreg       = 1'b0;
      oitf_wreg_rdidx = disp_rdidx;
      drained         = 1'b0;
      case (state_q)
         IDLE:    state_d = RUN;
         RUN:     if (flush) state_d = DRAIN;
         DRAIN:   if (!flush && cnt_q == '0) state_d = RUN;
         default: state_d = IDLE;
      endcase
      disp_ready = (state_q == RUN) & ~oitf_match1 & ~oitf_match2
                   & ~(disp_long & (cnt_q == CNT_FULL));
      oitf_wreg  = disp_valid & disp_ready & disp_long;
      drained    = (state_q == DRAIN) & (cnt_q == '0);
   end

   assign oitf_readen1  = disp_valid & disp_rs1en;
   assign oitf_readen2  = disp_valid & disp_rs2en;
   assign oitf_readidx1 = disp_rs1idx;
   assign oitf_readidx2 = disp_rs2idx;

`ifdef DISP_RR_ARB_EN
   // set when LSU holds priority for the next contended cycle
   logic lsu_turn_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         lsu_turn_q <= 1'b0;
      end else if (mdu_wb_valid & lsu_wb_valid) begin
         lsu_turn_q <= mdu_win;
      end
   end

   assign lsu_win = lsu_wb_valid & (~mdu_wb_valid | lsu_turn_q);
`else
   assign lsu_win = lsu_wb_valid;
`endif

   assign mdu_win       = mdu_wb_valid & ~lsu_win;
   assign mdu_wb_ready  = mdu_win;
   assign lsu_wb_ready  = lsu_win;
   assign oitf_wb       = mdu_wb_valid | lsu_wb_valid;
   assign oitf_wb_rdidx = lsu_win ? lsu_wb_rdidx : mdu_wb_rdidx;

   // allocate+retire together nets to zero, even from an empty count
   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      if (oitf_wb && cnt_q == '0) err_d = 1'b1;
      if (oitf_wreg && !oitf_wb) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (!oitf_wreg && oitf_wb && cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   assign cnt           = cnt_q;
   assign err_underflow = err_q;

endmodule

// File: tb/tb_oitf_disp_ctrl.sv
// Bench for oitf_disp_ctrl: directed test-plan sequence with literal expectations, then random stimulus,
// all checked every cycle against a queue-based model of outstanding entries that also plays the OITF.
module tb_oitf_disp_ctrl;
   localparam int DEPTH = 4;
   localparam int CNT_W = 3;
   localparam int REG_W = 5;
   localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, disp_valid, disp_long, rs1en, rs2en, flush, match1, match2, mdu_v, lsu_v;
   logic [REG_W-1:0] rs1idx, rs2idx, rdidx, mdu_idx, lsu_idx;
   logic d_ready, d_drained, d_wreg, d_wb, d_re1, d_re2, d_mdu_rdy, d_lsu_rdy, d_err;
   logic [REG_W-1:0] d_wreg_idx, d_wb_idx, d_ri1, d_ri2;
   logic [CNT_W-1:0] d_cnt;

   oitf_disp_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W), .REG_W(REG_W)) dut (
      .clk(clk), .rst(rst),
      .disp_valid(disp_valid), .disp_ready(d_ready), .disp_long(disp_long),
      .disp_rs1en(rs1en), .disp_rs2en(rs2en),
      .disp_rs1idx(rs1idx), .disp_rs2idx(rs2idx), .disp_rdidx(rdidx),
      .flush(flush), .drained(d_drained),
      .oitf_wreg(d_wreg), .oitf_wreg_rdidx(d_wreg_idx),
      .oitf_wb(d_wb), .oitf_wb_rdidx(d_wb_idx),
      .oitf_readen1(d_re1), .oitf_readen2(d_re2),
      .oitf_readidx1(d_ri1), .oitf_readidx2(d_ri2),
      .oitf_match1(match1), .oitf_match2(match2),
      .mdu_wb_valid(mdu_v), .mdu_wb_rdidx(mdu_idx), .mdu_wb_ready(d_mdu_rdy),
      .lsu_wb_valid(lsu_v), .lsu_wb_rdidx(lsu_idx), .lsu_wb_ready(d_lsu_rdy),
      .cnt(d_cnt), .err_underflow(d_err)
   );

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // model: mode, outstanding destinations in allocation order, sticky error, RR turn
   int               m_mode = M_IDLE;
   logic [REG_W-1:0] m_q[$];
   bit               m_err = 1'b0;
   bit               m_lsu_turn = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit in_q(input logic [REG_W-1:0] idx);
      foreach (m_q[i]) if (m_q[i] == idx) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit e_ready();
      return (m_mode == M_RUN) && !match1 && !match2 && !(disp_long && m_q.size() == DEPTH);
   endfunction

   function automatic bit e_wreg();
      return disp_valid && e_ready() && disp_long;
   endfunction

   function automatic bit e_lsu_win();
`ifdef DISP_RR_ARB_EN
      return lsu_v && (!mdu_v || m_lsu_turn);
`else
      return lsu_v;
`endif
   endfunction

   always @(posedge clk) begin
      int  old;
      bit  wr, wb, lw;
      if (rst) begin
         m_mode = M_IDLE;
         m_q.delete();
         m_err = 1'b0;
         m_lsu_turn = 1'b0;
      end else begin
         old = m_q.size();
         wr  = e_wreg();
         wb  = mdu_v | lsu_v;
         lw  = e_lsu_win();
         if (m_mode == M_IDLE) m_mode = M_RUN;
         else if (m_mode == M_RUN && flush) m_mode = M_DRAIN;
         else if (m_mode == M_DRAIN && !flush && old == 0) m_mode = M_RUN;
         if (mdu_v && lsu_v) m_lsu_turn = !lw;
         if (wb && old == 0) m_err = 1'b1;
         if (wr) m_q.push_back(rdidx);
         if (wb && (old > 0 || wr)) void'(m_q.pop_front());
      end
   end

   always @(negedge clk) begin
      bit ew, lw, wb;
      #2;
      if (chk_en) begin
         ew = e_wreg();
         lw = e_lsu_win();
         wb = mdu_v | lsu_v;
         chk("disp_ready", d_ready, e_ready());
         chk("oitf_wreg", d_wreg, ew);
         if (ew) chk("oitf_wreg_rdidx", d_wreg_idx, rdidx);
         chk("oitf_wb", d_wb, wb);
         chk("lsu_wb_ready", d_lsu_rdy, lw);
         chk("mdu_wb_ready", d_mdu_rdy, mdu_v && !lw);
         if (wb) chk("oitf_wb_rdidx", d_wb_idx, lw ? lsu_idx : mdu_idx);
         chk("oitf_readen1", d_re1, disp_valid & rs1en);
         chk("oitf_readen2", d_re2, disp_valid & rs2en);
         if (d_re1) chk("oitf_readidx1", d_ri1, rs1idx);
         if (d_re2) chk("oitf_readidx2", d_ri2, rs2idx);
         chk("cnt", d_cnt, m_q.size());
         chk("err_underflow", d_err, m_err);
         chk("drained", d_drained, (m_mode == M_DRAIN) && (m_q.size() == 0));
      end
   end

   task automatic defaults();
      rst = 1'b0; disp_valid = 1'b0; disp_long = 1'b0; rs1en = 1'b0; rs2en = 1'b0;
      rs1idx = '0; rs2idx = '0; rdidx = '0; flush = 1'b0;
      mdu_v = 1'b0; lsu_v = 1'b0; mdu_idx = '0; lsu_idx = '0;
      match1 = 1'b0; match2 = 1'b0;
   endtask

   task automatic next();
      @(negedge clk);
      defaults();
   endtask

   // drive OITF compare results from the model's outstanding list, then settle past the compare point
   task automatic apply();
      match1 = disp_valid & rs1en & in_q(rs1idx);
      match2 = disp_valid & rs2en & in_q(rs2idx);
      #3;
   endtask

   task automatic offer(input bit lng, input int rd);
      disp_valid = 1'b1; disp_long = lng; rdidx = REG_W'(rd);
   endtask

   initial begin
      bit fl;
      defaults();
      rst = 1'b1;
      next(); rst = 1'b1; apply();
      next(); rst = 1'b1; apply();
      chk_en = 1'b1;

      next(); offer(1, 5); apply();
      chk("idle_ready", d_ready, 0); chk("idle_cnt", d_cnt, 0);
      chk("idle_drained", d_drained, 0); chk("idle_wreg", d_wreg, 0);
      next(); offer(1, 5); apply();
      chk("alloc_wreg", d_wreg, 1); chk("alloc_rdidx", d_wreg_idx, 5);
      next(); offer(0, 6); rs1en = 1'b1; rs1idx = 5'd5; apply();
      chk("alloc_cnt", d_cnt, 1); chk("raw_hold", d_ready, 0);
      next(); offer(0, 6); rs1en = 1'b1; rs1idx = 5'd5; mdu_v = 1'b1; mdu_idx = 5'd5; apply();
      chk("raw_mdu_ready", d_mdu_rdy, 1); chk("raw_wb", d_wb, 1);
      next(); offer(0, 6); rs1en = 1'b1; rs1idx = 5'd5; apply();
      chk("raw_release", d_ready, 1); chk("raw_cnt", d_cnt, 0);

      for (int i = 0; i < 4; i++) begin
         next(); offer(1, 10 + i); apply();
         chk("fill_wreg", d_wreg, 1);
      end
      next(); offer(1, 20); apply();
      chk("full_cnt", d_cnt, 4); chk("full_long_hold", d_ready, 0);
      next(); offer(0, 21); apply();
      chk("full_short_ready", d_ready, 1); chk("full_short_wreg", d_wreg, 0);
      next(); mdu_v = 1'b1; mdu_idx = 5'd10; apply();
      next(); offer(1, 22); lsu_v = 1'b1; lsu_idx = 5'd11; apply();
      chk("unfull_cnt", d_cnt, 3); chk("unfull_wreg", d_wreg, 1);
      next(); offer(1, 23); apply();
      chk("alloc_retire_cnt", d_cnt, 3);

      for (int i = 0; i < 4; i++) begin
         next(); mdu_v = 1'b1; mdu_idx = 5'd30; lsu_v = 1'b1; lsu_idx = 5'd31; apply();
`ifdef DISP_RR_ARB_EN
         chk("arb_lsu", d_lsu_rdy, (i % 2 == 1)); chk("arb_mdu", d_mdu_rdy, (i % 2 == 0));
         chk("arb_idx", d_wb_idx, (i % 2 == 1) ? 31 : 30);
`else
         chk("arb_lsu", d_lsu_rdy, 1); chk("arb_mdu", d_mdu_rdy, 0);
         chk("arb_idx", d_wb_idx, 31);
`endif
      end
      next(); apply();
      chk("arb_cnt", d_cnt, 0);

      for (int i = 0; i < 2; i++) begin
         next(); offer(1, 1 + i); apply();
      end
      next(); flush = 1'b1; apply();
      chk("flush_cnt", d_cnt, 2);
      next(); flush = 1'b1; offer(0, 7); apply();
      chk("drain_hold", d_ready, 0); chk("drain_busy", d_drained, 0);
      next(); flush = 1'b1; mdu_v = 1'b1; mdu_idx = 5'd1; apply();
      next(); flush = 1'b1; lsu_v = 1'b1; lsu_idx = 5'd2; apply();
      chk("drain_cnt1", d_cnt, 1);
      next(); flush = 1'b1; apply();
      chk("drain_cnt0", d_cnt, 0); chk("drained_up", d_drained, 1);
      next(); apply();
      chk("drained_hold", d_drained, 1);
      next(); offer(0, 7); apply();
      chk("rerun_ready", d_ready, 1); chk("rerun_drained", d_drained, 0);

      next(); mdu_v = 1'b1; mdu_idx = 5'd9; apply();
      chk("pre_underflow", d_err, 0);
      next(); apply();
      chk("underflow_err", d_err, 1); chk("underflow_cnt", d_cnt, 0);
      next(); apply();
      chk("underflow_sticky", d_err, 1);

      for (int i = 0; i < 3; i++) begin
         next(); offer(1, 3 + i); apply();
      end
      next(); flush = 1'b1; apply();
      chk("pre_rst_cnt", d_cnt, 3);
      next(); flush = 1'b1; apply();
      next(); flush = 1'b1; rst = 1'b1; offer(1, 8); mdu_v = 1'b1; mdu_idx = 5'd3; apply();
      next(); flush = 1'b1; apply();
      chk("rst_cnt", d_cnt, 0); chk("rst_err", d_err, 0);
      chk("rst_ready", d_ready, 0); chk("rst_drained", d_drained, 0);

      fl = 1'b0;
      repeat (3000) begin
         next();
         if ($urandom_range(0, 29) == 0) fl = !fl;
         flush = fl;
         rst = ($urandom_range(0, 249) == 0);
         disp_valid = ($urandom_range(0, 9) < 7);
         disp_long = $urandom_range(0, 1) == 1;
         rs1en = $urandom_range(0, 1) == 1;
         rs2en = $urandom_range(0, 1) == 1;
         rs1idx = REG_W'($urandom_range(0, 7));
         rs2idx = REG_W'($urandom_range(0, 7));
         rdidx  = REG_W'($urandom_range(0, 7));
         mdu_v = ($urandom_range(0, 3) == 0);
         lsu_v = ($urandom_range(0, 3) == 0);
         mdu_idx = (m_q.size() > 0) ? m_q[0] : REG_W'($urandom_range(0, 31));
         lsu_idx = REG_W'($urandom_range(0, 31));
         apply();
      end

      next();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/oitf_disp_ctrl.md
# oitf_disp_ctrl

Dispatch and retire controller for the outstanding-instruction tracking FIFO (OITF) in the MIPS core. It sits between decode/dispatch and the OITF. It holds dispatch on a read-after-write hazard against an outstanding long-pipe destination, or when the OITF is full. It allocates OITF entries for long-pipe instructions and arbitrates the single OITF retire port between the multiply/divide unit (MDU) and the load/store unit (LSU).

## Interface
Parameters:
- DEPTH, 4: OITF entry count; must equal `OitfDepth`.
- CNT_W, 3: outstanding-count width; must satisfy 2^CNT_W > DEPTH.
- REG_W, 5: register index width (`RegAddrBusWidth`).

Ports (clock and reset first):
- clk  in  1  core clock; everything is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- disp_valid  in  1  decode offers an instruction.
- disp_ready  out  1  the instruction dispatches this cycle when disp_valid is also high.
- disp_long  in  1  the instruction is long-pipe (MDU or load) and needs an OITF entry.
- disp_rs1en, disp_rs2en  in  1 each  source read enables.
- disp_rs1idx, disp_rs2idx, disp_rdidx  in  REG_W each  source and destination indices.
- flush  in  1  pipeline flush request; sampled level.
- drained  out  1  high while in DRAIN with no outstanding entries.
- oitf_wreg, oitf_wreg_rdidx  out  1 / REG_W  allocation to the OITF.
- oitf_wb, oitf_wb_rdidx  out  1 / REG_W  retire to the OITF.
- oitf_readen1/2, oitf_readidx1/2  out  1 / REG_W  hazard compare ports.
- oitf_match1/2  in  1 each  compare results from the OITF, combinational.
- mdu_wb_valid / mdu_wb_rdidx / mdu_wb_ready  in / in REG_W / out  MDU writeback request.
- lsu_wb_valid / lsu_wb_rdidx / lsu_wb_ready  in / in REG_W / out  LSU writeback request.
- cnt  out  CNT_W  outstanding entry count.
- err_underflow  out  1  sticky; set when a retire occurs with cnt==0.

## Operation
- States:
  - IDLE (entered on reset) -> RUN unconditionally after 1 cycle.
  - RUN -> DRAIN when flush=1.
  - DRAIN -> RUN when flush=0 and cnt==0.
- Compare ports:
  - oitf_readen1 = disp_valid & disp_rs1en; oitf_readidx1 = disp_rs1idx.
  - Port 2 is driven the same way from rs2.
- disp_ready = (state==RUN) & ~oitf_match1 & ~oitf_match2 & ~(disp_long & cnt==DEPTH).
- Allocation:
  - oitf_wreg = disp_valid & disp_ready & disp_long; oitf_wreg_rdidx = disp_rdidx.
  - A short instruction dispatches without allocating.
- Retire arbitration, with at most one grant per cycle:
  - oitf_wb = mdu_wb_valid | lsu_wb_valid.
  - oitf_wb_rdidx comes from the winner; the winner's ready is 1 and the loser's ready is 0.
  - Retire is never blocked by state, including in DRAIN and IDLE.
- Count next value:
  - cnt + oitf_wreg - oitf_wb.
  - Allocation and retire in the same cycle leave cnt unchanged.
  - A retire with cnt==0 saturates cnt at 0 and sets err_underflow.
- DRAIN holds dispatch only. In-flight long ops still retire.

## Timing
- Reset values: state=IDLE, cnt=0, err_underflow=0, RR pointer=MDU-first. In the cycle after rst is sampled high, all combinational outputs are 0 (disp_ready=0, oitf_wreg=0, drained=0).
- rst asserted mid-operation: all registers return to their reset values at the next edge, regardless of pending requests.
- disp_ready and the grants are combinational: 0-cycle handshake, with no registered path from disp_valid to disp_ready other than state.
- cnt updates 1 cycle after the allocate/retire edge.
- An allocated entry is visible to the hazard compare from the next cycle. Same-cycle back-to-back dependent dispatch is covered by the OITF registering on the same edge.
- Full condition: cnt==DEPTH blocks only long instructions. A long instruction is accepted in the cycle cnt drops from DEPTH, i.e. the cycle after the retire edge.
- drained rises in the cycle after the final retire while flush is held.

## Configuration
- DISP_RR_ARB_EN defined: MDU/LSU retire arbitration is round-robin. When both request, the pointer flips to the non-winner after each grant. With only one requester, that requester wins and the pointer is unchanged.
- DISP_RR_ARB_EN undefined: fixed priority, LSU over MDU. The pointer register is removed.

## Test plan
- Reset then dispatch a long op, rd=5 -> oitf_wreg=1 with rdidx 5 in cycle 1 after IDLE; cnt=1 the next cycle.
- Long rd=5 outstanding, then dispatch rs1=5 -> disp_ready=0. Assert mdu_wb_valid with rdidx 5 -> mdu_wb_ready=1 and oitf_wb=1; disp_ready=1 from the next cycle.
- Allocate 4 long ops (cnt=4), then a 5th long op -> disp_ready=0. A short op with no hazard -> disp_ready=1. Simultaneous allocate and retire at cnt=3 -> cnt stays 3.
- mdu and lsu both valid for 4 cycles:
  - With DISP_RR_ARB_EN, grants are MDU, LSU, MDU, LSU.
  - Without it, grants are LSU in all 4 cycles.
- cnt=2, assert flush -> disp_ready=0; after 2 retires, cnt=0 and drained=1. Deassert flush -> RUN and disp_ready=1.
- Retire with cnt=0 -> err_underflow=1 (sticky), cnt stays 0. rst pulse mid-DRAIN with cnt=3 -> cnt=0, state=IDLE, err_underflow=0.
